mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and access sequencer for the 32 x 8 single-port data/instruction memory. It shares the memory between the CPU (port 0) and the program loader / debug port (port 1). It drives the memory's read/write strobes, address and write data according to the memory's timing: synchronous write, and a registered read sampled on the clock edge. It returns read data with a valid pulse. It sits between the CPU controller, the loader and the memory instance.

## Interface

Parameters:
- AWIDTH, 5, memory address width (32 words)
- DWIDTH, 8, memory data width

Ports (one clock, `clk`; reset `rst_` is asynchronous and active-low):
- clk  input  1  system clock, all state on rising edge
- rst_  input  1  asynchronous active-low reset
- req0, req1  input  1 each  access request from port 0 / port 1
- we0, we1  input  1 each  1 = write, 0 = read; valid while reqN high
- addr0, addr1  input  AWIDTH each  access address
- wdata0, wdata1  input  DWIDTH each  write data
- gnt0, gnt1  output  1 each  one-cycle pulse: request accepted, operands latched
- rvalid0, rvalid1  output  1 each  one-cycle pulse: rdataN holds read result
- rdata0, rdata1  output  DWIDTH each  read result, held until next rvalidN
- busy  output  1  high whenever state is not IDLE
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  AWIDTH  memory address
- mem_din  output  DWIDTH  memory write data
- mem_dout  input  DWIDTH  memory read data (registered inside memory)

## Operation

- FSM states: IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE.
- IDLE transitions:
  - No request: stay in IDLE.
  - Otherwise: select a winner, latch its addr and wdata into mem_addr and mem_din, and pulse gntN.
  - Winner we=0: assert mem_read, go to RD_ISSUE.
  - Winner we=1: assert mem_write, go to WR_ISSUE.
- RD_ISSUE: memory samples mem_read on this edge. Deassert mem_read, drop gnt, go to RD_CAPT.
- RD_CAPT: register mem_dout into rdataN of the winning port, pulse rvalidN, go to IDLE.
- WR_ISSUE: memory writes on this edge. Deassert mem_write, drop gnt, go to IDLE. No rvalid for writes.
- mem_read and mem_write are never high together. Both are registered outputs.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: selection per Configuration. The `last` register records the most recent winner.
- Requester rules:
  - Hold reqN, weN, addrN and wdataN stable until gntN is seen.
  - A request still high after gnt is treated as a new access.
  - Operands are latched at grant, so the requester may change them freely afterwards.
- Reset (asynchronous, any state): go to IDLE.
  - Outputs cleared: all gnt, all rvalid, mem_read, mem_write, busy = 0; mem_addr, mem_din, rdata0, rdata1 = 0.
  - `last` = 1, so port 0 wins the first tie.
  - An in-flight read is discarded: no rvalid after reset releases.

## Timing

- Edge E0 (IDLE samples req): gnt, mem_read or mem_write, and mem_addr go high/valid after E0.
- Read:
  - Memory captures at E1.
  - rdataN/rvalidN are valid after E2, i.e. 2 cycles after gnt.
  - Next grant is possible at E3, so read throughput is 1 per 3 cycles.
- Write:
  - Memory stores at E1.
  - Next grant is possible at E2, so write throughput is 1 per 2 cycles.
- Requests arriving while busy wait. They are not lost as long as req is held.
- A write followed immediately by a read of the same address returns the new data.

## Configuration

- `MEM_ARB_RR_EN` defined: round-robin on ties. The port not equal to `last` wins; `last` updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. Port 1 is served only when req0 is low in IDLE. `last` is still maintained but ignored.

## Test plan

- Reset: assert rst_ mid-simulation -> all outputs 0, busy=0, immediately and asynchronously, with no clock edge needed.
- Write then read: port 1 writes 8'h3C to addr 5'd5, then port 0 reads 5'd5 -> gnt1 one cycle; later gnt0; rvalid0=1 with rdata0=8'h3C exactly 2 cycles after gnt0.
- Tie under `MEM_ARB_RR_EN`: both ports hold read requests from reset -> grant order is 0,1,0,1; each grant 3 cycles apart.
- Tie without `MEM_ARB_RR_EN`: both ports hold requests -> port 0 is granted every time; after req0 drops, port 1 is granted in the next IDLE cycle.
- Reset mid-read: assert rst_ during RD_CAPT -> no rvalid pulse, rdata=0, state IDLE; a new read after release completes normally.
- Mutual exclusion: 200 random requests -> mem_read & mem_write never both 1; every read's rdata matches a reference model of the memory contents.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the 32x8 single-port memory (CPU = port 0, loader = port 1).
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise port 0 has fixed priority.

module mem_arb_rsp #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              capt,
  input  logic [DWIDTH-1:0] din,
  output logic              rvalid,
  output logic [DWIDTH-1:0] rdata
);
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= capt;
      if (capt) rdata <= din;
    end
  end
endmodule

module mem_arbiter #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout
);
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE} state_t;

  typedef struct packed {
    logic              we;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
  } req_t;

  state_t              state;
  req_t   [1:0]        rq;
  logic   [1:0]        gnt;
  logic   [1:0]        capt;
  logic   [1:0]        rvalid;
  logic   [1:0][DWIDTH-1:0] rdata;
  logic                last;
  logic                win;
  logic                sel;
  logic                tie_sel;

  assign rq[0] = {we0, addr0, wdata0};
  assign rq[1] = {we1, addr1, wdata1};

`ifdef MEM_ARB_RR_EN
  assign tie_sel = ~last;
`else
  // last is still tracked so both builds share one FSM; only RR consumes it.
  logic unused_last;
  assign unused_last = last;
  assign tie_sel     = 1'b0;
`endif

  always_comb begin
    sel = 1'b0;
    if (req1 && !req0)     sel = 1'b1;
    else if (req1 && req0) sel = tie_sel;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      last      <= 1'b1;
      win       <= 1'b0;
      gnt       <= 2'b00;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt      <= sel ? 2'b10 : 2'b01;
            win      <= sel;
            last     <= sel;
            mem_addr <= rq[sel].addr;
            mem_din  <= rq[sel].wdata;
            if (rq[sel].we) begin
              mem_write <= 1'b1;
              state     <= WR_ISSUE;
            end else begin
              mem_read <= 1'b1;
              state    <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          mem_read <= 1'b0;
          gnt      <= 2'b00;
          state    <= RD_CAPT;
        end
        // mem_dout is valid here because the memory registered it on the RD_ISSUE edge.
        RD_CAPT: state <= IDLE;
        WR_ISSUE: begin
          mem_write <= 1'b0;
          gnt       <= 2'b00;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign capt = (state == RD_CAPT) ? (win ? 2'b10 : 2'b01) : 2'b00;

  for (genvar p = 0; p < 2; p++) begin : g_rsp
    mem_arb_rsp #(.DWIDTH(DWIDTH)) u_rsp (
      .clk    (clk),
      .rst_   (rst_),
      .capt   (capt[p]),
      .din    (mem_dout),
      .rvalid (rvalid[p]),
      .rdata  (rdata[p])
    );
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid[0];
  assign rvalid1 = rvalid[1];
  assign rdata0  = rdata[0];
  assign rdata1  = rdata[1];
  assign busy    = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 32x8 memory (registered read, sync write).
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [4:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, mem_read, mem_write;
  logic [7:0] rdata0, rdata1, mem_din;
  logic [7:0] mem_dout = 8'h00;
  logic [4:0] mem_addr;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [32];
  logic [7:0] ref_mem [32];

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk(clk), .rst_(rst_),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_din;
    if (mem_read)  mem_dout <= mem[mem_addr];
  end

  // One access from port p, starting and ending on a negedge.
  task automatic access(input int p, input logic w, input logic [4:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int gcyc, output int vcyc,
                        output logic g2, output logic mx);
    rd = '0; gcyc = -1; vcyc = -1; g2 = 1'b0; mx = 1'b0;
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_read && mem_write) mx = 1'b1;
      if ((p == 0) ? gnt0 : gnt1) begin gcyc = i; break; end
    end
    req0 = 0; req1 = 0;
    if (gcyc < 0) return;
    if (w) begin
      ref_mem[a] = d;
      @(negedge clk);
      if (mem_read && mem_write) mx = 1'b1;
      g2 = (p == 0) ? gnt0 : gnt1;
    end else begin
      for (int i = 1; i <= 6; i++) begin
        @(negedge clk);
        if (mem_read && mem_write) mx = 1'b1;
        if (i == 1) g2 = (p == 0) ? gnt0 : gnt1;
        if ((p == 0) ? rvalid0 : rvalid1) begin
          vcyc = i;
          rd = (p == 0) ? rdata0 : rdata1;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [44:0] outs;
    rst_ = 0;
    repeat (2) @(negedge clk);
    outs = {gnt0, gnt1, rvalid0, rvalid1, busy, mem_read, mem_write, mem_addr, mem_din, rdata0, rdata1};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_state: got %h expected 0", outs); end
    rst_ = 1;
    @(negedge clk);
    // start a write, then pull reset mid-cycle with no clock edge
    req0 = 1; we0 = 1; addr0 = 5'd9; wdata0 = 8'hA5;
    @(negedge clk);
    checks++;
    if ({gnt0, mem_write, busy, mem_addr, mem_din} !== {3'b111, 5'd9, 8'hA5}) begin
      errors++;
      $display("FAIL reset_pre_write: got gnt0=%b wr=%b busy=%b addr=%0d din=%h expected 1 1 1 9 a5",
               gnt0, mem_write, busy, mem_addr, mem_din);
    end
    req0 = 0; we0 = 0;
    #2 rst_ = 0;
    #1;
    outs = {gnt0, gnt1, rvalid0, rvalid1, busy, mem_read, mem_write, mem_addr, mem_din, rdata0, rdata1};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_async: got %h expected 0", outs); end
    @(negedge clk);
    rst_ = 1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [7:0] rd; int g, v; logic g2, mx;
    access(1, 1'b1, 5'd5, 8'h3C, rd, g, v, g2, mx);
    checks++;
    if (g !== 0 || g2 !== 1'b0 || mx !== 1'b0) begin
      errors++;
      $display("FAIL wr_grant: got gcyc=%0d gnt_next=%b mutex=%b expected 0 0 0", g, g2, mx);
    end
    access(0, 1'b0, 5'd5, 8'h00, rd, g, v, g2, mx);
    checks++;
    if (g !== 0 || g2 !== 1'b0) begin
      errors++; $display("FAIL rd_grant: got gcyc=%0d gnt_next=%b expected 0 0", g, g2);
    end
    checks++;
    if (v !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", v); end
    checks++;
    if (rd !== 8'h3C) begin errors++; $display("FAIL rd_data: got %h expected 3c", rd); end
  endtask

  task automatic test_tie();
    int exp_port [4];
    int exp_cyc  [4] = '{0, 3, 6, 9};
    int got_port [4];
    int got_cyc  [4];
    int n = 0;
    int n0 = 0;
    logic both = 1'b0;
`ifdef MEM_ARB_RR_EN
    exp_port = '{0, 1, 0, 1};
`else
    exp_port = '{0, 0, 0, 1};
`endif
    for (int i = 0; i < 4; i++) begin got_port[i] = -1; got_cyc[i] = -1; end
    @(negedge clk);
    rst_ = 0;
    req0 = 1; we0 = 0; addr0 = 5'd5;
    req1 = 1; we1 = 0; addr1 = 5'd7;
    @(negedge clk);
    rst_ = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both = 1'b1;
      if ((gnt0 || gnt1) && n < 4) begin
        got_port[n] = gnt1 ? 1 : 0;
        got_cyc[n]  = c;
        n++;
        if (gnt0) n0++;
`ifndef MEM_ARB_RR_EN
        if (n0 == 3) req0 = 0;
`endif
        if (n == 4) begin req0 = 0; req1 = 0; end
      end
    end
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (both !== 1'b0) begin errors++; $display("FAIL tie_both_gnt: got 1 expected 0"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_port[i] !== exp_port[i] || got_cyc[i] !== exp_cyc[i]) begin
        errors++;
        $display("FAIL tie_grant%0d: got port %0d at cycle %0d expected port %0d at cycle %0d",
                 i, got_port[i], got_cyc[i], exp_port[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rd; int g, v; logic g2, mx;
    logic seen = 1'b0;
    req0 = 1; we0 = 0; addr0 = 5'd5;
    @(negedge clk);
    req0 = 0;
    checks++;
    if (gnt0 !== 1'b1) begin errors++; $display("FAIL rst_rd_gnt: got %b expected 1", gnt0); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rdata0 !== 8'h3C) begin
      errors++; $display("FAIL rst_rd_pre: got busy=%b rdata0=%h expected 1 3c", busy, rdata0);
    end
    #2 rst_ = 0;
    #1;
    checks++;
    if ({rvalid0, busy, rdata0} !== 10'b0) begin
      errors++; $display("FAIL rst_rd_clear: got rvalid0=%b busy=%b rdata0=%h expected 0 0 00",
                         rvalid0, busy, rdata0);
    end
    @(negedge clk);
    rst_ = 1;
    repeat (3) begin
      @(negedge clk);
      if (rvalid0 || rvalid1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_rd_no_rvalid: got 1 expected 0"); end
    access(0, 1'b0, 5'd5, 8'h00, rd, g, v, g2, mx);
    checks++;
    if (g !== 0 || v !== 2 || rd !== 8'h3C) begin
      errors++; $display("FAIL rst_rd_after: got gcyc=%0d vcyc=%0d rd=%h expected 0 2 3c", g, v, rd);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd; int g, v; logic g2, mx;
    int p; logic w; logic [4:0] a; logic [7:0] d;
    logic any_mx = 1'b0;
    int bad_timing = 0;
    for (int k = 0; k < 200; k++) begin
      p = $urandom_range(0, 1);
      w = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 31));
      d = 8'($urandom_range(0, 255));
      access(p, w, a, d, rd, g, v, g2, mx);
      if (mx) any_mx = 1'b1;
      if (g != 0 || (!w && v != 2)) bad_timing++;
      if (!w) begin
        checks++;
        if (rd !== ref_mem[a]) begin
          errors++; $display("FAIL rand_rd%0d: port %0d addr %0d got %h expected %h", k, p, a, rd, ref_mem[a]);
        end
      end
    end
    checks++;
    if (any_mx !== 1'b0) begin errors++; $display("FAIL rand_mutex: got 1 expected 0"); end
    checks++;
    if (bad_timing !== 0) begin errors++; $display("FAIL rand_timing: got %0d bad expected 0", bad_timing); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    test_reset();
    test_write_read();
    test_reset_mid_read();
    test_tie();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
